// File: rtl/io_xbar_pkt_arbiter_pkg.sv
// Shared constants and types for the io_xbar output-port packet arbiter
// and its round-robin picker.
package io_xbar_pkt_arbiter_pkg;

    localparam int DATA_WIDTH      = 64;
    localparam int IO_XBAR_NUM_IN  = 8;
    localparam int IO_XBAR_IDX_W   = 3;
    localparam int IO_XBAR_LEN_LSB = 22;
    localparam int IO_XBAR_LEN_W   = 8;
    localparam int IO_XBAR_CREDITS = 4;

    typedef enum logic {
        IO_XBAR_ARB_IDLE = 1'b0,
        IO_XBAR_ARB_BODY = 1'b1
    } io_xbar_arb_state_t;

    typedef logic [DATA_WIDTH-1:0] flit_t;

    function automatic logic [IO_XBAR_NUM_IN-1:0] idx_onehot(input logic [IO_XBAR_IDX_W-1:0] idx);
        logic [IO_XBAR_NUM_IN-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/io_xbar_pkt_arbiter_if.sv
// Requester and downstream signals of one io_xbar output-port arbiter.
// master = arbiter view, slave = input FIFOs / downstream view.
interface io_xbar_pkt_arbiter_if;
    import io_xbar_pkt_arbiter_pkg::*;

    logic [IO_XBAR_NUM_IN-1:0]            in_valid;
    logic [IO_XBAR_NUM_IN*DATA_WIDTH-1:0] in_data;
    logic [IO_XBAR_NUM_IN-1:0]            thanks_out;
    flit_t                                data_out;
    logic                                 valid_out;
    logic                                 yummy_in;
    logic [IO_XBAR_IDX_W-1:0]             grant_idx;
    logic                                 busy;

    modport master (
        input  in_valid,
        input  in_data,
        input  yummy_in,
        output thanks_out,
        output data_out,
        output valid_out,
        output grant_idx,
        output busy
    );

    modport slave (
        output in_valid,
        output in_data,
        output yummy_in,
        input  thanks_out,
        input  data_out,
        input  valid_out,
        input  grant_idx,
        input  busy
    );

endinterface

// File: rtl/io_xbar_rr_pick.sv
// Rotating-priority encoder: first set req bit after position ptr, wrapping mod 8.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the grant is taken.
module io_xbar_rr_pick
    import io_xbar_pkt_arbiter_pkg::*;
(
    input  logic [IO_XBAR_NUM_IN-1:0] req,
    input  logic [IO_XBAR_IDX_W-1:0]  ptr,
    output logic [IO_XBAR_IDX_W-1:0]  gnt_idx,
    output logic                      gnt_any
);

    logic [IO_XBAR_IDX_W-1:0] cand;
    logic                     found;

    // ptr itself is scanned last, so the previous winner has lowest priority
    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= IO_XBAR_NUM_IN; k++) begin
            cand = ptr + IO_XBAR_IDX_W'(k);
            if (!found && req[cand]) begin
                gnt_idx = cand;
                found   = 1'b1;
            end
        end
    end

    assign gnt_any = |req;

endmodule

// File: rtl/io_xbar_pkt_arbiter.sv
// Packet-granular round-robin scheduler for one io_xbar output port (8 inputs).
// Latency: flit popped in cycle N is on data_out/valid_out in cycle N+1.
// Backpressure: valid/yummy credits; no flit is popped while the credit count is zero.
module io_xbar_pkt_arbiter
    import io_xbar_pkt_arbiter_pkg::*;
#(
    parameter int CREDITS = IO_XBAR_CREDITS,
    parameter int LEN_LSB = IO_XBAR_LEN_LSB,
    parameter int LEN_W   = IO_XBAR_LEN_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    io_xbar_pkt_arbiter_if.master xif
);

    localparam int                CRED_W   = $clog2(CREDITS + 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

    io_xbar_arb_state_t       state_q, state_d;
    logic [CRED_W-1:0]        credits_q, credits_d;
    logic [LEN_W-1:0]         remaining_q, remaining_d;
    logic [IO_XBAR_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IO_XBAR_IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic                     busy_q, busy_d;
    logic                     valid_out_q, valid_out_d;
    flit_t                    data_out_q, data_out_d;

    logic [IO_XBAR_IDX_W-1:0] pick_idx;
    logic                     pick_any;
    logic [IO_XBAR_IDX_W-1:0] sel_idx;
    logic                     sel_vld;
    flit_t                    sel_flit;
    logic [LEN_W-1:0]         hdr_len;
    logic                     cred_ok;
    logic                     send;
    logic                     hdr_send;
    logic                     tail_send;

    io_xbar_rr_pick u_rr_pick (
        .req     (xif.in_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // In BODY only the locked owner is considered; in IDLE the round-robin winner.
    // rst_n gates send so thanks_out is quiet while reset is held.
    always_comb begin
        sel_idx   = (state_q == IO_XBAR_ARB_IDLE) ? pick_idx : grant_idx_q;
        sel_vld   = (state_q == IO_XBAR_ARB_IDLE) ? pick_any : xif.in_valid[grant_idx_q];
        sel_flit  = xif.in_data[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
        hdr_len   = sel_flit[LEN_LSB +: LEN_W];
        cred_ok   = (credits_q != '0);
        send      = rst_n && cred_ok && sel_vld;
        hdr_send  = send && (state_q == IO_XBAR_ARB_IDLE);
        tail_send = send && (state_q == IO_XBAR_ARB_BODY) && (remaining_q == LEN_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IO_XBAR_ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IO_XBAR_ARB_IDLE: if (hdr_send && (hdr_len != '0)) state_d = IO_XBAR_ARB_BODY;
            IO_XBAR_ARB_BODY: if (tail_send)                    state_d = IO_XBAR_ARB_IDLE;
            default:                                            state_d = IO_XBAR_ARB_IDLE;
        endcase
    end

    // rr_ptr and grant_idx move only on header acceptance, never on body flits
    always_comb begin
        remaining_d = remaining_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        busy_d      = busy_q;
        valid_out_d = send;
        data_out_d  = send ? sel_flit : data_out_q;
        if (hdr_send) begin
            rr_ptr_d    = sel_idx;
            grant_idx_d = sel_idx;
            remaining_d = hdr_len;
            busy_d      = (hdr_len != '0);
        end else if (send) begin
            remaining_d = remaining_q - LEN_W'(1);
            busy_d      = !tail_send;
        end
    end

    // A yummy at full count is a protocol error; the counter saturates.
    always_comb begin
        credits_d = credits_q;
        if (send && !xif.yummy_in) begin
            credits_d = credits_q - CRED_W'(1);
        end else if (xif.yummy_in && !send && (credits_q != CRED_MAX)) begin
            credits_d = credits_q + CRED_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q   <= CRED_MAX;
            remaining_q <= '0;
            rr_ptr_q    <= IO_XBAR_IDX_W'(IO_XBAR_NUM_IN - 1);
            grant_idx_q <= '0;
            busy_q      <= 1'b0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            credits_q   <= credits_d;
            remaining_q <= remaining_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            busy_q      <= busy_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
        end
    end

    assign xif.thanks_out = send ? idx_onehot(sel_idx) : '0;
    assign xif.data_out   = data_out_q;
    assign xif.valid_out  = valid_out_q;
    assign xif.grant_idx  = grant_idx_q;
    assign xif.busy       = busy_q;

    a_no_yummy_at_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(xif.yummy_in && (credits_q == CRED_MAX)));

endmodule
